// File: rtl/fpu_addsub_pipe.sv
// fpu_addsub_pipe: handshaked, multi-cycle IEEE-style add/sub with generic EXP_W/MAN_W.
// Optional FPU_STICKY_STATUS_EN adds status_clr/status_sticky accumulated flag ports.
module fpu_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   op_sub,
    input  logic [EXP_W+MAN_W:0]   op_a_in,
    input  logic [EXP_W+MAN_W:0]   op_b_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   data_out,
    output logic [3:0]             status_out
`ifdef FPU_STICKY_STATUS_EN
    ,
    input  logic                   status_clr,
    output logic [3:0]             status_sticky
`endif
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int M  = MAN_W + 4;
    localparam int E  = EXP_W + 2;
    localparam int LW = $clog2(M + 1);
    localparam logic signed [E-1:0] EMAX = E'((1 << EXP_W) - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;
    state_t r_state, w_next;

    logic [W-1:0]          r_a, r_b, r_spec_val;
    logic [3:0]            r_spec_st;
    logic                  r_spec, r_sign, r_sub;
    logic [M-1:0]          r_ml, r_ms, r_mn;
    logic [M:0]            r_sum;
    logic signed [E-1:0]   r_exp;

    logic [EXP_W-1:0]      w_ea, w_eb;
    logic [W-2:0]          w_maga, w_magb;
    logic                  w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_nan, w_swap;
    logic [W-1:0]          w_l, w_s, w_res;
    logic [M-1:0]          w_ml, w_ms_raw, w_ms;
    logic [31:0]           w_diff, w_sh;
    logic [2*M-1:0]        w_wide;
    logic [LW-1:0]         w_lz;
    logic                  w_up, w_inex, w_ovf, w_unf;
    logic [MAN_W:0]        w_rm;
    logic signed [E-1:0]   w_ef;
    logic [3:0]            w_st;

    assign in_ready  = r_state == S_IDLE;
    assign out_valid = r_state == S_DONE;

    always_comb begin
        w_next = r_state;
        if (r_state == S_IDLE)
            w_next = in_valid ? S_ALIGN : S_IDLE;
        else if (r_state == S_ALIGN)
            w_next = S_ADD;
        else if (r_state == S_ADD)
            w_next = S_NORM;
        else if (r_state == S_NORM)
            w_next = S_ROUND;
        else if (r_state == S_ROUND)
            w_next = S_DONE;
        else
            w_next = out_ready ? S_IDLE : S_DONE;
    end

    // Denormal inputs flush to zero before the magnitude compare.
    assign w_ea     = r_a[W-2:MAN_W];
    assign w_eb     = r_b[W-2:MAN_W];
    assign w_maga   = (w_ea == '0) ? '0 : r_a[W-2:0];
    assign w_magb   = (w_eb == '0) ? '0 : r_b[W-2:0];
    assign w_a_inf  = (&w_ea) && (r_a[MAN_W-1:0] == '0);
    assign w_b_inf  = (&w_eb) && (r_b[MAN_W-1:0] == '0);
    assign w_a_nan  = (&w_ea) && (r_a[MAN_W-1:0] != '0);
    assign w_b_nan  = (&w_eb) && (r_b[MAN_W-1:0] != '0);
    assign w_nan    = w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (r_a[W-1] ^ r_b[W-1]));
    assign w_swap   = w_magb > w_maga;
    assign w_l      = w_swap ? {r_b[W-1], w_magb} : {r_a[W-1], w_maga};
    assign w_s      = w_swap ? {r_a[W-1], w_maga} : {r_b[W-1], w_magb};
    assign w_ml     = {|w_l[W-2:MAN_W], w_l[MAN_W-1:0], 3'b000};
    assign w_ms_raw = {|w_s[W-2:MAN_W], w_s[MAN_W-1:0], 3'b000};
    assign w_diff   = 32'(w_l[W-2:MAN_W]) - 32'(w_s[W-2:MAN_W]);
    assign w_sh     = (w_diff > 32'(M - 1)) ? 32'(M - 1) : w_diff;
    assign w_wide   = {w_ms_raw, {M{1'b0}}} >> w_sh;
    assign w_ms     = {w_wide[2*M-1:M+1], w_wide[M] | (|w_wide[M-1:0])};

    always_comb begin
        w_lz = '0;
        for (int i = 0; i < M; i++)
            if (r_sum[i]) w_lz = LW'(M - 1 - i);
    end

    // r_mn = {hidden, mantissa, guard, round, sticky}; a clear hidden bit means a zero sum.
    assign w_up   = r_mn[2] & (r_mn[3] | r_mn[1] | r_mn[0]);
    assign w_inex = |r_mn[2:0];
    assign w_rm   = {1'b0, r_mn[M-2:3]} + (MAN_W+1)'(w_up);
    assign w_ef   = r_exp + E'(w_rm[MAN_W]);
    assign w_ovf  = w_ef >= EMAX;
    assign w_unf  = w_ef[E-1] | (w_ef == '0);
    assign w_res  = r_spec ? r_spec_val :
                    !r_mn[M-1] ? {~r_sub & r_sign, {(W-1){1'b0}}} :
                    w_ovf ? {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                    w_unf ? {r_sign, {(W-1){1'b0}}} :
                    {r_sign, w_ef[EXP_W-1:0], w_rm[MAN_W-1:0]};
    assign w_st   = r_spec ? r_spec_st : !r_mn[M-1] ? 4'b0001 : w_ovf ? 4'b1010 :
                    w_unf ? 4'b1100 : {w_inex, 2'b00, ~w_inex};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_spec     <= 1'b0;
            r_spec_val <= '0;
            r_spec_st  <= '0;
            r_sign     <= 1'b0;
            r_sub      <= 1'b0;
            r_ml       <= '0;
            r_ms       <= '0;
            r_mn       <= '0;
            r_sum      <= '0;
            r_exp      <= '0;
            data_out   <= '0;
            status_out <= '0;
        end else begin
            if (r_state == S_IDLE && in_valid) begin
                r_a <= op_a_in;
                r_b <= {op_b_in[W-1] ^ op_sub, op_b_in[W-2:0]};
            end
            if (r_state == S_ALIGN) begin
                r_spec     <= w_a_inf | w_b_inf | w_a_nan | w_b_nan;
                r_spec_val <= w_nan ? QNAN : w_a_inf ? r_a : r_b;
                r_spec_st  <= w_nan ? 4'b0000 : 4'b0001;
                r_sign     <= w_l[W-1];
                r_sub      <= w_l[W-1] ^ w_s[W-1];
                r_ml       <= w_ml;
                r_ms       <= w_ms;
                r_exp      <= {2'b00, w_l[W-2:MAN_W]};
            end
            if (r_state == S_ADD)
                r_sum <= r_sub ? {1'b0, r_ml} - {1'b0, r_ms} : {1'b0, r_ml} + {1'b0, r_ms};
            if (r_state == S_NORM) begin
                r_mn  <= r_sum[M] ? {r_sum[M:2], |r_sum[1:0]} : r_sum[M-1:0] << w_lz;
                r_exp <= r_sum[M] ? r_exp + E'(1) : r_exp - E'(w_lz);
            end
            if (r_state == S_ROUND) begin
                data_out   <= w_res;
                status_out <= w_st;
            end
        end
    end

`ifdef FPU_STICKY_STATUS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            status_sticky <= '0;
        else if (status_clr)
            status_sticky <= '0;
        else if (r_state == S_DONE && out_ready)
            status_sticky <= status_sticky | {status_out[3:1], 1'b0};
    end
`endif
endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// tb_fpu_addsub_pipe: directed fp32 and fp16 vectors with hand-computed results.
module tb_fpu_addsub_pipe;
    logic        clk = 1'b0, rst = 1'b1, op_sub = 1'b0, out_ready = 1'b0, status_clr = 1'b0;
    logic        f_iv = 1'b0, h_iv = 1'b0;
    logic [31:0] f_a = '0, f_b = '0;
    logic [15:0] h_a = '0, h_b = '0;
    logic        f_ir, f_ov, h_ir, h_ov;
    logic [31:0] f_d;
    logic [15:0] h_d;
    logic [3:0]  f_st, h_st;
`ifdef FPU_STICKY_STATUS_EN
    logic [3:0]  f_sk, h_sk;
`endif
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    fpu_addsub_pipe #(.EXP_W(8), .MAN_W(23)) u_f32 (
        .clk(clk), .rst(rst), .in_valid(f_iv), .in_ready(f_ir), .op_sub(op_sub),
        .op_a_in(f_a), .op_b_in(f_b), .out_valid(f_ov), .out_ready(out_ready),
        .data_out(f_d), .status_out(f_st)
`ifdef FPU_STICKY_STATUS_EN
        , .status_clr(status_clr), .status_sticky(f_sk)
`endif
    );

    fpu_addsub_pipe #(.EXP_W(5), .MAN_W(10)) u_f16 (
        .clk(clk), .rst(rst), .in_valid(h_iv), .in_ready(h_ir), .op_sub(op_sub),
        .op_a_in(h_a), .op_b_in(h_b), .out_valid(h_ov), .out_ready(out_ready),
        .data_out(h_d), .status_out(h_st)
`ifdef FPU_STICKY_STATUS_EN
        , .status_clr(status_clr), .status_sticky(h_sk)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic op(input string tag, input bit h, input logic [31:0] a, input logic [31:0] b,
                      input logic sub, input logic [31:0] ed, input logic [3:0] es, input int hold);
        int n = 0;
        @(negedge clk);
        op_sub = sub;
        if (h) begin
            h_iv = 1'b1; h_a = a[15:0]; h_b = b[15:0];
        end else begin
            f_iv = 1'b1; f_a = a; f_b = b;
        end
        @(posedge clk);
        #1 f_iv = 1'b0;
        h_iv = 1'b0;
        while (!(h ? h_ov : f_ov) && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        chk({tag, "/latency"}, 32'(n), 32'd4);
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        if (hold > 0) begin
            chk({tag, "/held_valid"}, {31'h0, h ? h_ov : f_ov}, 32'd1);
            chk({tag, "/held_ready"}, {31'h0, h ? h_ir : f_ir}, 32'd0);
        end
        chk({tag, "/data"}, h ? {16'h0, h_d} : f_d, ed);
        chk({tag, "/status"}, {28'h0, h ? h_st : f_st}, {28'h0, es});
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, "/idle"}, {30'h0, h ? h_ir : f_ir, h ? h_ov : f_ov}, 32'd2);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {f_ir, f_ov, f_st, h_ir, h_ov, h_st}, {1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0});
        chk("reset_data", f_d, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        op("add_1_2",   0, 32'h3f800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0001, 10);
        op("sub_5_3",   0, 32'h40a00000, 32'h40400000, 1'b1, 32'h40000000, 4'b0001, 0);
        op("sub_3_3",   0, 32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 4'b0001, 0);
        op("neg_add",   0, 32'hbfc00000, 32'hc0200000, 1'b0, 32'hc0800000, 4'b0001, 0);
        op("tie_even",  0, 32'h3f800000, 32'h33800000, 1'b0, 32'h3f800000, 4'b1000, 0);
        op("round_up",  0, 32'h3f800000, 32'h33c00000, 1'b0, 32'h3f800001, 4'b1000, 0);
        op("overflow",  0, 32'h7f7fffff, 32'h7f7fffff, 1'b0, 32'h7f800000, 4'b1010, 0);
        op("inf_m_inf", 0, 32'h7f800000, 32'h7f800000, 1'b1, 32'h7fc00000, 4'b0000, 0);
        op("nan_in",    0, 32'h7f800001, 32'h3f800000, 1'b0, 32'h7fc00000, 4'b0000, 0);
        op("inf_fin",   0, 32'h3f800000, 32'hff800000, 1'b0, 32'hff800000, 4'b0001, 0);
        op("negzero",   0, 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0001, 0);
        op("underflow", 0, 32'h00800000, 32'h00c00000, 1'b1, 32'h80000000, 4'b1100, 0);
        op("ftz_denorm",0, 32'h00000001, 32'h3f800000, 1'b0, 32'h3f800000, 4'b0001, 0);
        op("pre_rst",   0, 32'h40a00000, 32'h3f800000, 1'b0, 32'h40c00000, 4'b0001, 0);

        @(negedge clk);
        f_iv = 1'b1; f_a = 32'h3f800000; f_b = 32'h40000000; op_sub = 1'b0;
        @(posedge clk);
        #1 f_iv = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_align_data", f_d, 32'h0);
        chk("rst_align_ctl", {28'h0, f_ir, f_ov, 2'b00}, {28'h0, 1'b1, 1'b0, 2'b00});
        chk("rst_align_st", {28'h0, f_st}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        op("post_rst",  0, 32'h3f800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0001, 0);

        op("h_add",     1, 32'h3c00, 32'h4000, 1'b0, 32'h4200, 4'b0001, 0);
        op("h_ovf",     1, 32'h7bff, 32'h7bff, 1'b0, 32'h7c00, 4'b1010, 0);
`ifdef FPU_STICKY_STATUS_EN
        chk("h_sticky", {28'h0, h_sk}, 32'b1010);
        op("h_exact",   1, 32'h4000, 32'h3c00, 1'b1, 32'h3c00, 4'b0001, 0);
        chk("h_sticky_hold", {28'h0, h_sk}, 32'b1010);
        chk("f_sticky", {28'h0, f_sk}, 32'h0);
        @(negedge clk);
        status_clr = 1'b1;
        @(posedge clk);
        #1 status_clr = 1'b0;
        chk("h_sticky_clr", {28'h0, h_sk}, 32'h0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
